// File: rtl/spiflash_prog_pkg.sv
// Shared constants for the SPI flash programming sequencer: flash opcodes,
// register map, CTRL fields, operation encodings and the sequencer state type.
package spiflash_prog_pkg;

    localparam logic [7:0] OPC_WREN  = 8'h06;
    localparam logic [7:0] OPC_PP    = 8'h02;
    localparam logic [7:0] OPC_SE    = 8'h20;
    localparam logic [7:0] OPC_RDSR  = 8'h05;
    localparam logic [7:0] OPC_DUMMY = 8'h00;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_ADDR  = 2'd1;
    localparam logic [1:0] REG_WDATA = 2'd2;

    localparam logic [1:0] OP_CLR   = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RDSR  = 2'b11;

    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_TMO    = 1;
    localparam int CTRL_BERR   = 2;
    localparam int CTRL_SR_LSB = 8;

    // Bit of the cfg word that asks the spiflash block to raise CS.
    localparam int CS_RELEASE_BIT = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_WREL,
        S_CMD,
        S_ADR,
        S_DAT,
        S_PREL,
        S_POLL_CMD,
        S_POLL_DUM,
        S_POLL_REL,
        S_GAP
    } state_t;

    // Flash address goes out MSB first.
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
        case (idx)
            2'd0:    addr_byte = a[23:16];
            2'd1:    addr_byte = a[15:8];
            default: addr_byte = a[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spiflash_cfg_xfer.sv
// One cfg-port byte transaction: cyc+stb until accepted, cyc until ack; o_done is
// combinational with the ack. Requests are taken only while cyc is low, so cyc idles >=1 clk.
module spiflash_cfg_xfer
    import spiflash_prog_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [7:0]  i_byte,
    input  logic        i_release,
    output logic        o_done,
    output logic [7:0]  o_rx_byte,
    output logic        o_m_cyc,
    output logic        o_m_cfg_stb,
    output logic [31:0] o_m_data,
    input  logic        i_m_stall,
    input  logic        i_m_ack,
    input  logic [7:0]  i_m_rdata
);

    logic       r_cyc;
    logic       r_stb;
    logic [7:0] r_byte;
    logic       r_rel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cyc  <= 1'b0;
            r_stb  <= 1'b0;
            r_byte <= 8'h00;
            r_rel  <= 1'b0;
        end else if (!r_cyc) begin
            if (i_req) begin
                r_cyc  <= 1'b1;
                r_stb  <= 1'b1;
                r_byte <= i_byte;
                r_rel  <= i_release;
            end
        end else begin
            if (!i_m_stall)
                r_stb <= 1'b0;
            if (i_m_ack) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
            end
        end
    end

    always_comb begin
        o_m_data                 = '0;
        o_m_data[7:0]            = r_byte;
        o_m_data[CS_RELEASE_BIT] = r_rel;
    end

    assign o_m_cyc     = r_cyc;
    assign o_m_cfg_stb = r_stb;
    assign o_done      = r_cyc && i_m_ack;
    assign o_rx_byte   = i_m_rdata;

endmodule

// File: rtl/spiflash_prog.sv
// Wishbone-driven WREN/PP/SE/RDSR sequencer on the spiflash cfg port; slave acks 1 clk after stb,
// never stalls. GAP lasts POLL_GAP clks on top of the 1-clk cyc gap. Option: SPIFLASH_PROG_TIMEOUT_EN.
module spiflash_prog
    import spiflash_prog_pkg::*;
#(
    parameter int POLL_GAP = 64
`ifdef SPIFLASH_PROG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_POLLS = 2**20
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_m_cyc,
    output logic        o_m_cfg_stb,
    output logic        o_m_we,
    output logic [31:0] o_m_data,
    input  logic        i_m_stall,
    input  logic        i_m_ack,
    input  logic [31:0] i_m_data,
    output logic        o_busy
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [1:0]         r_cnt;
    logic [23:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [7:0]         r_sr;
    logic               r_timeout_err;
    logic               r_busy_err;
    logic               r_ack;
    logic [31:0]        r_rdata;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic               w_busy;
    logic               w_wr;
    logic               w_start;
    logic               w_done;
    logic               w_req;
    logic               w_release;
    logic               w_gap_end;
    logic               w_timeout;
    logic [7:0]         w_tx_byte;
    logic [7:0]         w_rx_byte;
    logic [31:0]        w_ctrl_rd;
    logic               w_unused_m;

    assign w_busy    = (r_state != S_IDLE);
    assign w_wr      = i_wb_cyc && i_wb_stb && i_wb_we;
    assign w_start   = w_wr && !w_busy && (i_wb_addr == REG_CTRL) && (i_wb_data[1:0] != OP_CLR);
    assign w_gap_end = (r_gap_cnt == GAP_W'(POLL_GAP - 1));
    assign w_unused_m = &{1'b0, i_m_data[31:8]};

`ifdef SPIFLASH_PROG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_POLLS + 1);
    logic [TMO_W-1:0] r_poll_cnt;

    // Counts completed polls that still reported WIP in the current operation.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_start)
            r_poll_cnt <= '0;
        else if (r_state == S_POLL_REL && w_done && r_sr[0])
            r_poll_cnt <= r_poll_cnt + 1'b1;
    end

    assign w_timeout = (r_poll_cnt == TMO_W'(TIMEOUT_POLLS - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_next = (i_wb_data[1:0] == OP_RDSR) ? S_POLL_CMD : S_WREN;
            S_WREN:     if (w_done) w_next = S_WREL;
            S_WREL:     if (w_done) w_next = S_CMD;
            S_CMD:      if (w_done) w_next = S_ADR;
            S_ADR:      if (w_done && r_cnt == 2'd2) w_next = (r_op == OP_PROG) ? S_DAT : S_PREL;
            S_DAT:      if (w_done && r_cnt == 2'd3) w_next = S_PREL;
            S_PREL:     if (w_done) w_next = S_POLL_CMD;
            S_POLL_CMD: if (w_done) w_next = S_POLL_DUM;
            S_POLL_DUM: if (w_done) w_next = S_POLL_REL;
            S_POLL_REL: begin
                if (w_done) begin
                    if (r_op == OP_RDSR || !r_sr[0] || w_timeout)
                        w_next = S_IDLE;
                    else
                        w_next = S_GAP;
                end
            end
            S_GAP:      if (w_gap_end) w_next = S_POLL_CMD;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req     = 1'b1;
        w_release = 1'b0;
        w_tx_byte = 8'h00;
        case (r_state)
            S_WREN:     w_tx_byte = OPC_WREN;
            S_WREL,
            S_PREL,
            S_POLL_REL: w_release = 1'b1;
            S_CMD:      w_tx_byte = (r_op == OP_PROG) ? OPC_PP : OPC_SE;
            S_ADR:      w_tx_byte = addr_byte(r_addr, r_cnt);
            S_DAT:      w_tx_byte = r_wdata[{r_cnt, 3'b000} +: 8];
            S_POLL_CMD: w_tx_byte = OPC_RDSR;
            S_POLL_DUM: w_tx_byte = OPC_DUMMY;
            default:    w_req = 1'b0;
        endcase
    end

    always_comb begin
        w_ctrl_rd                       = '0;
        w_ctrl_rd[CTRL_BUSY]            = w_busy;
        w_ctrl_rd[CTRL_TMO]             = r_timeout_err;
        w_ctrl_rd[CTRL_BERR]            = r_busy_err;
        w_ctrl_rd[CTRL_SR_LSB +: 8]     = r_sr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op          <= OP_CLR;
            r_cnt         <= 2'd0;
            r_addr        <= 24'h0;
            r_wdata       <= 32'h0;
            r_sr          <= 8'h00;
            r_timeout_err <= 1'b0;
            r_busy_err    <= 1'b0;
            r_ack         <= 1'b0;
            r_rdata       <= 32'h0;
            r_gap_cnt     <= '0;
        end else begin
            r_ack <= i_wb_cyc && i_wb_stb;
            case (i_wb_addr)
                REG_CTRL:  r_rdata <= w_ctrl_rd;
                REG_ADDR:  r_rdata <= {8'h00, r_addr};
                REG_WDATA: r_rdata <= r_wdata;
                default:   r_rdata <= 32'h0;
            endcase

            if (w_wr) begin
                if (w_busy) begin
                    r_busy_err <= 1'b1;
                end else begin
                    case (i_wb_addr)
                        REG_CTRL: begin
                            if (i_wb_data[1:0] == OP_CLR) begin
                                r_timeout_err <= 1'b0;
                                r_busy_err    <= 1'b0;
                            end else begin
                                r_op <= i_wb_data[1:0];
                            end
                        end
                        REG_ADDR:  r_addr  <= i_wb_data[23:0];
                        REG_WDATA: r_wdata <= i_wb_data;
                        default: ;
                    endcase
                end
            end

            // Shared 2-bit counter: 3 address bytes, then 4 data bytes wrapping back to 0.
            if (w_start)
                r_cnt <= 2'd0;
            else if (w_done && (r_state == S_ADR || r_state == S_DAT))
                r_cnt <= (r_state == S_ADR && r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;

            if (r_state == S_POLL_DUM && w_done)
                r_sr <= w_rx_byte;

            if (r_state == S_POLL_REL && w_done && r_op != OP_RDSR && r_sr[0] && w_timeout)
                r_timeout_err <= 1'b1;

            if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt + 1'b1;
            else
                r_gap_cnt <= '0;
        end
    end

    spiflash_cfg_xfer u_xfer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (w_req),
        .i_byte      (w_tx_byte),
        .i_release   (w_release),
        .o_done      (w_done),
        .o_rx_byte   (w_rx_byte),
        .o_m_cyc     (o_m_cyc),
        .o_m_cfg_stb (o_m_cfg_stb),
        .o_m_data    (o_m_data),
        .i_m_stall   (i_m_stall),
        .i_m_ack     (i_m_ack),
        .i_m_rdata   (i_m_data[7:0])
    );

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rdata;
    assign o_m_we     = o_m_cyc;
    assign o_busy     = w_busy;

endmodule

// File: tb/tb_spiflash_prog.sv
// Directed bench for spiflash_prog with a cfg-port flash model that logs every byte.
module tb_spiflash_prog;

    localparam int GAP = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdat;
    logic        wb_stall, wb_ack;
    logic [31:0] wb_rdat;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_dat;
    logic        m_stall = 1'b1;
    logic        m_ack   = 1'b0;
    logic [31:0] m_rdat  = 32'h0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] log_v   [0:255];
    int         log_gap [0:255];
    logic       log_ok  [0:255];
    int         log_n   = 0;
    int         dum_n   = 0;
    int         low_run = 0;
    int         rise_gap = 0;
    int         d_cnt   = 0;
    logic [8:0] prev_v  = 9'h0;
    logic [7:0] sr_seq  [0:7];
    int         sr_len  = 1;
    int         dbase   = 0;

    always #5 clk = ~clk;

    spiflash_prog #(
        .POLL_GAP(GAP)
`ifdef SPIFLASH_PROG_TIMEOUT_EN
        , .TIMEOUT_POLLS(4)
`endif
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wb_cyc    (wb_cyc),
        .i_wb_stb    (wb_stb),
        .i_wb_we     (wb_we),
        .i_wb_addr   (wb_addr),
        .i_wb_data   (wb_wdat),
        .o_wb_stall  (wb_stall),
        .o_wb_ack    (wb_ack),
        .o_wb_data   (wb_rdat),
        .o_m_cyc     (m_cyc),
        .o_m_cfg_stb (m_stb),
        .o_m_we      (m_we),
        .o_m_data    (m_dat),
        .i_m_stall   (m_stall),
        .i_m_ack     (m_ack),
        .i_m_data    (m_rdat),
        .o_busy      (busy)
    );

    function automatic logic [7:0] sr_at(input int i);
        int k;
        k = (i >= sr_len) ? sr_len - 1 : i;
        return sr_seq[k];
    endfunction

    // Flash model: stalls the first stb clock, acks 2 clks after acceptance,
    // answers the byte following a 0x05 with the next scripted status value.
    always @(posedge clk) begin
        m_ack <= 1'b0;
        if (rst) begin
            d_cnt   <= 0;
            m_stall <= 1'b1;
        end else begin
            if (!m_cyc) low_run <= low_run + 1;
            else        low_run <= 0;
            if (m_cyc && m_stb && m_stall) begin
                m_stall  <= 1'b0;
                rise_gap <= low_run;
            end else if (m_cyc && m_stb && !m_stall) begin
                log_v[log_n % 256]   <= m_dat[8:0];
                log_gap[log_n % 256] <= rise_gap;
                log_ok[log_n % 256]  <= m_we && (m_dat[31:9] == 23'h0);
                log_n   <= log_n + 1;
                prev_v  <= m_dat[8:0];
                m_stall <= 1'b1;
                d_cnt   <= 2;
                if (prev_v == 9'h005) begin
                    m_rdat <= {24'hABCDEF, sr_at(dum_n - dbase)};
                    dum_n  <= dum_n + 1;
                end else begin
                    m_rdat <= 32'hABCDEFEE;
                end
            end
            if (d_cnt != 0) begin
                d_cnt <= d_cnt - 1;
                if (d_cnt == 1) m_ack <= 1'b1;
            end
        end
    end

    task automatic wb_write(input logic [1:0] a, input logic [31:0] v, output logic ack);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdat = v;
        @(negedge clk);
        ack = wb_ack;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] v, output logic ack);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
        @(negedge clk);
        ack = wb_ack;
        v   = wb_rdat;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        ack;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({m_cyc, m_stb, m_we, busy, wb_ack, wb_stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 000000", {m_cyc, m_stb, m_we, busy, wb_ack, wb_stall});
        end
        n_tests++;
        if (m_dat !== 32'h0 || wb_rdat !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got m=%h wb=%h want 0", m_dat, wb_rdat);
        end
        rst = 1'b0;
        wb_read(2'd0, v, ack);
        n_tests++;
        if (ack !== 1'b1 || v !== 32'h0) begin
            n_fail++; $display("FAIL reset_ctrl_rd: got ack=%b %h want 1 00000000", ack, v);
        end
        @(negedge clk);
        n_tests++;
        if (wb_ack !== 1'b0) begin
            n_fail++; $display("FAIL ack_single: got %b want 0", wb_ack);
        end
        wb_read(2'd1, v, ack);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", v); end
        wb_read(2'd2, v, ack);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", v); end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        logic        ack;
        int          base;
        base = log_n;
        wb_write(2'd1, 32'hFF012345, ack);
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", ack); end
        wb_read(2'd1, v, ack);
        n_tests++;
        if (v !== 32'h00012345) begin n_fail++; $display("FAIL addr_rb: got %h want 00012345", v); end
        wb_write(2'd2, 32'hA1B2C3D4, ack);
        wb_read(2'd2, v, ack);
        n_tests++;
        if (v !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL wdata_rb: got %h want a1b2c3d4", v); end
        wb_write(2'd3, 32'hDEADBEEF, ack);
        wb_read(2'd3, v, ack);
        n_tests++;
        if (v !== 32'h0 || busy !== 1'b0 || log_n != base) begin
            n_fail++; $display("FAIL reserved: got %h busy=%b xfers=%0d want 0 0 0", v, busy, log_n - base);
        end
    endtask

    task automatic test_program();
        logic [8:0]  exp_v [0:13];
        logic [31:0] v;
        logic        ack, ok;
        int          base, errs;
        exp_v = '{9'h006, 9'h100, 9'h002, 9'h001, 9'h023, 9'h045, 9'h0D4,
                  9'h0C3, 9'h0B2, 9'h0A1, 9'h100, 9'h005, 9'h000, 9'h100};
        sr_seq[0] = 8'h00; sr_len = 1; dbase = dum_n;
        base = log_n;
        wb_write(2'd0, 32'h1, ack);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL prog_busy_rise: got %b want 1", busy); end
        wait_idle(ok);
        n_tests++;
        if (ok !== 1'b1 || log_n - base != 14) begin
            n_fail++; $display("FAIL prog_len: idle=%b got %0d want 14", ok, log_n - base);
        end
        for (int i = 0; i < 14; i++) begin
            n_tests++;
            if (log_v[(base + i) % 256] !== exp_v[i]) begin
                n_fail++; $display("FAIL prog_byte%0d: got %h want %h", i, log_v[(base + i) % 256], exp_v[i]);
            end
        end
        errs = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0 && log_gap[(base + i) % 256] != 1) errs++;
            if (log_ok[(base + i) % 256] !== 1'b1) errs++;
        end
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL prog_gap_we: got %0d bad want 0", errs); end
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL prog_ctrl: got %h want 0", v); end
    endtask

    task automatic test_erase_poll();
        logic [8:0]  exp_v [0:15];
        logic [31:0] v;
        logic        ack, fell_on_ack;
        int          base;
        exp_v = '{9'h006, 9'h100, 9'h020, 9'h000, 9'h0F0, 9'h000, 9'h100,
                  9'h005, 9'h000, 9'h100, 9'h005, 9'h000, 9'h100, 9'h005, 9'h000, 9'h100};
        sr_seq[0] = 8'h03; sr_seq[1] = 8'h03; sr_seq[2] = 8'h00; sr_len = 3; dbase = dum_n;
        wb_write(2'd1, 32'h0000F000, ack);
        base = log_n;
        wb_write(2'd0, 32'h2, ack);
        fell_on_ack = 1'b0;
        for (int i = 0; i < 4000 && busy; i++) begin
            fell_on_ack = m_ack && m_cyc && busy;
            @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b0 || fell_on_ack !== 1'b1) begin
            n_fail++; $display("FAIL erase_busy_fall: busy=%b after_ack=%b want 0 1", busy, fell_on_ack);
        end
        n_tests++;
        if (log_n - base != 16 || dum_n - dbase != 3) begin
            n_fail++; $display("FAIL erase_len: got %0d xfers %0d polls want 16 3", log_n - base, dum_n - dbase);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (log_v[(base + i) % 256] !== exp_v[i]) begin
                n_fail++; $display("FAIL erase_byte%0d: got %h want %h", i, log_v[(base + i) % 256], exp_v[i]);
            end
        end
        n_tests++;
        if (log_gap[(base + 7) % 256] != 1 || log_gap[(base + 10) % 256] != GAP + 1
            || log_gap[(base + 13) % 256] != GAP + 1) begin
            n_fail++; $display("FAIL poll_gap: got %0d %0d %0d want 1 %0d %0d", log_gap[(base + 7) % 256],
                log_gap[(base + 10) % 256], log_gap[(base + 13) % 256], GAP + 1, GAP + 1);
        end
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL erase_ctrl: got %h want 0", v); end
    endtask

    task automatic test_busy_write();
        logic [31:0] v;
        logic        ack, ok;
        int          base, wren;
        sr_seq[0] = 8'h01; sr_seq[1] = 8'h01; sr_seq[2] = 8'h00; sr_len = 3; dbase = dum_n;
        wb_write(2'd1, 32'h000AB000, ack);
        base = log_n;
        wb_write(2'd0, 32'h2, ack);
        wb_write(2'd0, 32'h2, ack);
        n_tests++;
        if (ack !== 1'b1) begin n_fail++; $display("FAIL busy_wr_ack: got %b want 1", ack); end
        wb_write(2'd1, 32'h00111111, ack);
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h00000005) begin n_fail++; $display("FAIL busy_ctrl: got %h want 00000005", v); end
        wait_idle(ok);
        wren = 0;
        for (int i = 0; i < log_n - base; i++)
            if (log_v[(base + i) % 256] === 9'h006) wren++;
        n_tests++;
        if (ok !== 1'b1 || wren != 1 || log_v[(base + 3) % 256] !== 9'h00A
            || log_v[(base + 4) % 256] !== 9'h0B0 || log_v[(base + 5) % 256] !== 9'h000) begin
            n_fail++; $display("FAIL busy_ignored: idle=%b wren=%0d adr=%h %h %h want 1 1 00a 0b0 000", ok, wren,
                log_v[(base + 3) % 256], log_v[(base + 4) % 256], log_v[(base + 5) % 256]);
        end
        wb_read(2'd1, v, ack);
        n_tests++;
        if (v !== 32'h000AB000) begin n_fail++; $display("FAIL busy_addr: got %h want 000ab000", v); end
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h00000004) begin n_fail++; $display("FAIL busy_err_sticky: got %h want 00000004", v); end
        wb_write(2'd0, 32'h0, ack);
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL err_clear: got %h want 0", v); end
    endtask

    task automatic test_read_sr();
        logic [31:0] v;
        logic        ack, ok;
        int          base;
        sr_seq[0] = 8'h5C; sr_len = 1; dbase = dum_n;
        base = log_n;
        wb_write(2'd0, 32'h3, ack);
        wait_idle(ok);
        n_tests++;
        if (ok !== 1'b1 || log_n - base != 3 || log_v[base % 256] !== 9'h005
            || log_v[(base + 1) % 256] !== 9'h000 || log_v[(base + 2) % 256] !== 9'h100) begin
            n_fail++; $display("FAIL rdsr_seq: idle=%b len=%0d first=%h want 1 3 005", ok, log_n - base, log_v[base % 256]);
        end
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h00005C00) begin n_fail++; $display("FAIL rdsr_5c: got %h want 00005c00", v); end
        sr_seq[0] = 8'h5D; dbase = dum_n;
        base = log_n;
        wb_write(2'd0, 32'h3, ack);
        wait_idle(ok);
        wb_read(2'd0, v, ack);
        n_tests++;
        if (ok !== 1'b1 || log_n - base != 3 || v !== 32'h00005D00) begin
            n_fail++; $display("FAIL rdsr_wip_once: idle=%b len=%0d ctrl=%h want 1 3 00005d00", ok, log_n - base, v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        ack, hit;
        int          base;
        sr_seq[0] = 8'h00; sr_len = 1; dbase = dum_n;
        wb_write(2'd1, 32'h00012345, ack);
        base = log_n;
        wb_write(2'd0, 32'h1, ack);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (log_n - base >= 4) begin hit = 1'b1; break; end
        end
        n_tests++;
        if (hit !== 1'b1 || m_cyc !== 1'b1) begin
            n_fail++; $display("FAIL mid_reach_adr: reached=%b cyc=%b want 1 1", hit, m_cyc);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({m_cyc, m_stb, m_we, busy} !== 4'b0 || m_dat !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_out: got %b %h want 0000 0", {m_cyc, m_stb, m_we, busy}, m_dat);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_read(2'd1, v, ack);
        n_tests++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL mid_reset_addr: got %h want 0", v); end
        repeat (5) @(negedge clk);
        n_tests++;
        if (m_cyc !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_quiet: cyc=%b busy=%b want 0 0", m_cyc, busy);
        end
    endtask

`ifdef SPIFLASH_PROG_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] v;
        logic        ack, ok;
        int          base, polls;
        sr_seq[0] = 8'h01; sr_len = 1; dbase = dum_n;
        wb_write(2'd1, 32'h00001000, ack);
        base = log_n;
        wb_write(2'd0, 32'h2, ack);
        wait_idle(ok);
        polls = 0;
        for (int i = 0; i < log_n - base; i++)
            if (log_v[(base + i) % 256] === 9'h005) polls++;
        n_tests++;
        if (ok !== 1'b1 || polls != 4) begin
            n_fail++; $display("FAIL tmo_polls: idle=%b got %0d want 4", ok, polls);
        end
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h00000102) begin n_fail++; $display("FAIL tmo_err: got %h want 00000102", v); end
        wb_write(2'd0, 32'h0, ack);
        wb_read(2'd0, v, ack);
        n_tests++;
        if (v !== 32'h00000100) begin n_fail++; $display("FAIL tmo_clear: got %h want 00000100", v); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_wdat = 32'h0;
        test_reset();
        test_regs();
        test_program();
        test_erase_poll();
        test_busy_write();
        test_read_sr();
        test_reset_mid();
`ifdef SPIFLASH_PROG_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
